// File: rtl/stack_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stack_unit_pkg
//  Purpose  : Shared constants and types for the EX-stage hardware stack.
//             The decoder, bypass network and register-dump logic size
//             themselves from STACK_DEPTH / STACK_WIDTH so that they all
//             agree with the stack_unit instance.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package stack_unit_pkg;

   localparam int STACK_DEPTH = 16;
   localparam int STACK_WIDTH = 32;

   // Source of the visible pop_data value.
   // POP_SRC_REG : the local holding register (reset, underflow, pass-through)
   // POP_SRC_RAM : the registered read port of stack_ram
   typedef enum logic {
      POP_SRC_REG = 1'b0,
      POP_SRC_RAM = 1'b1
   } pop_src_e;

endpackage : stack_unit_pkg
`default_nettype wire

// File: rtl/stack_ram.sv
`default_nettype none
// ============================================================================
//  Module   : stack_ram
//  Purpose  : DEPTH x WIDTH simple dual-port storage for the stack. One
//             synchronous write port and one synchronous read port. A read
//             and write to the same address in the same cycle returns the
//             old contents (read-before-write). rdata holds while re=0.
//             Not reset, so it maps onto FPGA block RAM.
//  Ports    : clk            - clock
//             we/waddr/wdata - write enable, address, data
//             re/raddr       - read enable, address
//             rdata          - registered read data
//  Revision : 1.0 - initial release
// ============================================================================
module stack_ram #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rdata;

   // Both updates are non-blocking in one process, so a colliding read
   // samples the array before this edge's write lands.
   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[waddr] <= wdata;
      end
      if (re) begin
         r_rdata <= r_mem[raddr];
      end
   end

   assign rdata = r_rdata;

endmodule : stack_ram
`default_nettype wire

// File: rtl/stack_unit.sv
`default_nettype none
// ============================================================================
//  Module   : stack_unit
//  Purpose  : EX-stage LIFO stack executing decoder PUSH/POP operations.
//             Popped word appears on pop_data one cycle after the pop.
//             Tracks occupancy, full/empty and sticky ovf/unf error flags.
//  Ports    : clk, rst_n   - clock, synchronous active-low reset
//             push, pop    - stack operations from ID/EX
//             kill         - suppress this cycle's push/pop
//             push_data    - value to push
//             clr_err      - clear ovf/unf (a same-cycle error still sets)
//             pop_data     - popped value, valid the cycle after a pop
//             count        - occupancy 0..DEPTH
//             full, empty  - occupancy status
//             ovf, unf     - sticky overflow / underflow flags
//  Revision : 1.0 - initial release
// ============================================================================
module stack_unit
   import stack_unit_pkg::*;
#(
   parameter int WIDTH = STACK_WIDTH,
   parameter int DEPTH = STACK_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       kill,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       clr_err,
   output logic [WIDTH-1:0]           pop_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty,
   output logic                       ovf,
   output logic                       unf
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int AW = $clog2(DEPTH);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [CW-1:0]    r_count;
   logic             r_ovf;
   logic             r_unf;
   logic [WIDTH-1:0] r_hold;      // pop_data value when not sourced by RAM
   pop_src_e         r_src;

   // ------------------------------------------------------------------
   // Combinational control
   // ------------------------------------------------------------------
   logic             w_p;
   logic             w_q;
   logic             w_full;
   logic             w_empty;
   logic [CW-1:0]    w_top;
   logic [CW-1:0]    w_count_nxt;
   logic             w_ovf_set;
   logic             w_unf_set;
   logic             w_hold_load;
   logic [WIDTH-1:0] w_hold_val;
   pop_src_e         w_src_nxt;
   logic             w_we;
   logic [AW-1:0]    w_waddr;
   logic             w_re;
   logic [WIDTH-1:0] w_rdata;

   assign w_p     = push & ~kill;
   assign w_q     = pop  & ~kill;
   assign w_full  = (r_count == CW'(DEPTH));
   assign w_empty = (r_count == '0);
   assign w_top   = r_count - 1'b1;

   always_comb begin
      w_count_nxt = r_count;
      w_ovf_set   = 1'b0;
      w_unf_set   = 1'b0;
      w_hold_load = 1'b0;
      w_hold_val  = '0;
      w_src_nxt   = r_src;
      w_we        = 1'b0;
      w_waddr     = r_count[AW-1:0];
      w_re        = 1'b0;

      unique case ({w_p, w_q})
         2'b10: begin
            if (!w_full) begin
               w_we        = 1'b1;
               w_count_nxt = r_count + 1'b1;
            end else begin
               w_ovf_set   = 1'b1;
            end
         end
         2'b01: begin
            if (!w_empty) begin
               w_re        = 1'b1;
               w_count_nxt = r_count - 1'b1;
               w_src_nxt   = POP_SRC_RAM;
            end else begin
               w_unf_set   = 1'b1;
               w_hold_load = 1'b1;
               w_src_nxt   = POP_SRC_REG;
            end
         end
         2'b11: begin
            if (!w_empty) begin
               // Replace top: RAM returns the old word, then overwrites it.
               w_re        = 1'b1;
               w_we        = 1'b1;
               w_waddr     = w_top[AW-1:0];
               w_src_nxt   = POP_SRC_RAM;
            end else begin
               // Empty stack: the pushed word passes straight through.
               w_hold_load = 1'b1;
               w_hold_val  = push_data;
               w_src_nxt   = POP_SRC_REG;
            end
         end
         default: ;
      endcase

      // Reset cycle takes priority: nothing is written to storage.
      if (!rst_n) begin
         w_we = 1'b0;
         w_re = 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Storage
   // ------------------------------------------------------------------
   stack_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (w_we),
      .waddr (w_waddr),
      .wdata (push_data),
      .re    (w_re),
      .raddr (w_top[AW-1:0]),
      .rdata (w_rdata)
   );

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_count <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
         r_hold  <= '0;
         r_src   <= POP_SRC_REG;
      end else begin
         r_count <= w_count_nxt;
         r_ovf   <= w_ovf_set | (r_ovf & ~clr_err);
         r_unf   <= w_unf_set | (r_unf & ~clr_err);
         r_src   <= w_src_nxt;
         if (w_hold_load) begin
            r_hold <= w_hold_val;
         end
      end
   end

   // Both mux inputs are flop outputs that hold when idle, so pop_data
   // is effectively registered with one-cycle latency.
   assign pop_data = (r_src == POP_SRC_RAM) ? w_rdata : r_hold;
   assign count    = r_count;
   assign full     = w_full;
   assign empty    = w_empty;
   assign ovf      = r_ovf;
   assign unf      = r_unf;

endmodule : stack_unit
`default_nettype wire

// File: tb/tb_stack_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stack_unit
//  Purpose  : Self-checking bench for stack_unit using a table of directed
//             vectors with hand-computed expected outputs.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stack_unit;
   import stack_unit_pkg::*;

   localparam int WIDTH = STACK_WIDTH;
   localparam int DEPTH = STACK_DEPTH;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             push;
   logic             pop;
   logic             kill;
   logic [WIDTH-1:0] push_data;
   logic             clr_err;
   logic [WIDTH-1:0] pop_data;
   logic [CW-1:0]    count;
   logic             full;
   logic             empty;
   logic             ovf;
   logic             unf;

   always #5 clk = ~clk;

   stack_unit #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .pop       (pop),
      .kill      (kill),
      .push_data (push_data),
      .clr_err   (clr_err),
      .pop_data  (pop_data),
      .count     (count),
      .full      (full),
      .empty     (empty),
      .ovf       (ovf),
      .unf       (unf)
   );

   typedef struct {
      logic             rst_n;
      logic             push;
      logic             pop;
      logic             kill;
      logic             clr_err;
      logic [WIDTH-1:0] din;
      int               e_count;
      logic [WIDTH-1:0] e_pd;
      logic             e_ovf;
      logic             e_unf;
   } vec_t;

   vec_t vq[$];
   int   n_vec = 0;
   int   n_bad = 0;

   function automatic vec_t mk(logic r, logic p, logic q, logic k, logic c,
                               logic [WIDTH-1:0] d, int ec,
                               logic [WIDTH-1:0] epd, logic eo, logic eu);
      vec_t v;
      v.rst_n = r; v.push = p; v.pop = q; v.kill = k; v.clr_err = c;
      v.din = d; v.e_count = ec; v.e_pd = epd; v.e_ovf = eo; v.e_unf = eu;
      return v;
   endfunction

   task automatic chk(int idx, string name, logic [63:0] act, logic [63:0] exp);
      if (act !== exp) begin
         n_bad++;
         $display("FAIL vec%0d %s: got 0x%0h expected 0x%0h", idx, name, act, exp);
      end
   endtask

   // Drive one vector, clock it, then sample 1 time unit after the edge.
   task automatic apply(int idx, vec_t v);
      rst_n     = v.rst_n;
      push      = v.push;
      pop       = v.pop;
      kill      = v.kill;
      clr_err   = v.clr_err;
      push_data = v.din;
      @(posedge clk);
      #1;
      n_vec++;
      chk(idx, "count",    64'(count),    64'(v.e_count));
      chk(idx, "pop_data", 64'(pop_data), 64'(v.e_pd));
      chk(idx, "ovf",      64'(ovf),      64'(v.e_ovf));
      chk(idx, "unf",      64'(unf),      64'(v.e_unf));
      chk(idx, "full",     64'(full),     64'(v.e_count == DEPTH));
      chk(idx, "empty",    64'(empty),    64'(v.e_count == 0));
   endtask

   initial begin
      rst_n = 1'b0; push = 1'b0; pop = 1'b0; kill = 1'b0;
      clr_err = 1'b0; push_data = '0;

      //           rst p  q  k  clr din          cnt pop_data     ovf unf
      // Reset, then idle
      vq.push_back(mk(0, 0, 0, 0, 0, 32'h0,      0, 32'h0,       0, 0));
      vq.push_back(mk(0, 0, 0, 0, 0, 32'h0,      0, 32'h0,       0, 0));
      vq.push_back(mk(1, 0, 0, 0, 0, 32'h0,      0, 32'h0,       0, 0));
      // LIFO order
      vq.push_back(mk(1, 1, 0, 0, 0, 32'h11,     1, 32'h0,       0, 0));
      vq.push_back(mk(1, 1, 0, 0, 0, 32'h22,     2, 32'h0,       0, 0));
      vq.push_back(mk(1, 1, 0, 0, 0, 32'h33,     3, 32'h0,       0, 0));
      vq.push_back(mk(1, 0, 1, 0, 0, 32'h0,      2, 32'h33,      0, 0));
      vq.push_back(mk(1, 0, 1, 0, 0, 32'h0,      1, 32'h22,      0, 0));
      vq.push_back(mk(1, 0, 1, 0, 0, 32'h0,      0, 32'h11,      0, 0));
      vq.push_back(mk(1, 0, 0, 0, 0, 32'h0,      0, 32'h11,      0, 0));
      // Underflow, clear
      vq.push_back(mk(1, 0, 1, 0, 0, 32'h0,      0, 32'h0,       0, 1));
      vq.push_back(mk(1, 0, 0, 0, 1, 32'h0,      0, 32'h0,       0, 0));
      // Pass-through on empty
      vq.push_back(mk(1, 1, 1, 0, 0, 32'hABCD,   0, 32'hABCD,    0, 0));
      // Replace on non-empty (read-before-write)
      vq.push_back(mk(1, 1, 0, 0, 0, 32'h5,      1, 32'hABCD,    0, 0));
      vq.push_back(mk(1, 1, 1, 0, 0, 32'h6,      1, 32'h5,       0, 0));
      vq.push_back(mk(1, 0, 1, 0, 0, 32'h0,      0, 32'h6,       0, 0));
      // Kill suppresses push and pop
      vq.push_back(mk(1, 1, 0, 1, 0, 32'h77,     0, 32'h6,       0, 0));
      vq.push_back(mk(1, 0, 1, 1, 0, 32'h0,      0, 32'h6,       0, 0));
      // Overflow: fill with 1..DEPTH
      for (int k = 1; k <= DEPTH; k++)
         vq.push_back(mk(1, 1, 0, 0, 0, WIDTH'(k), k, 32'h6,     0, 0));
      vq.push_back(mk(1, 1, 0, 0, 0, 32'hDEAD,   16, 32'h6,      1, 0));
      vq.push_back(mk(1, 0, 1, 0, 0, 32'h0,      15, 32'h10,     1, 0));
      vq.push_back(mk(1, 0, 0, 0, 1, 32'h0,      15, 32'h10,     0, 0));
      // Replace while full: no overflow
      vq.push_back(mk(1, 1, 0, 0, 0, 32'h99,     16, 32'h10,     0, 0));
      vq.push_back(mk(1, 1, 1, 0, 0, 32'hAA,     16, 32'h99,     0, 0));
      vq.push_back(mk(1, 0, 1, 0, 0, 32'h0,      15, 32'hAA,     0, 0));
      // Reset mid-stream with a push pending
      vq.push_back(mk(0, 0, 0, 0, 0, 32'h0,      0, 32'h0,       0, 0));
      vq.push_back(mk(1, 1, 0, 0, 0, 32'h1,      1, 32'h0,       0, 0));
      vq.push_back(mk(1, 1, 0, 0, 0, 32'h2,      2, 32'h0,       0, 0));
      vq.push_back(mk(0, 1, 0, 0, 0, 32'h3,      0, 32'h0,       0, 0));
      vq.push_back(mk(1, 0, 1, 0, 0, 32'h0,      0, 32'h0,       0, 1));
      // Push then immediate pop, no bubble
      vq.push_back(mk(1, 1, 0, 0, 0, 32'h4,      1, 32'h0,       0, 1));
      vq.push_back(mk(1, 0, 1, 0, 0, 32'h0,      0, 32'h4,       0, 1));
      // clr_err with a same-cycle underflow: set wins
      vq.push_back(mk(1, 0, 1, 0, 1, 32'h0,      0, 32'h0,       0, 1));
      vq.push_back(mk(1, 0, 0, 0, 1, 32'h0,      0, 32'h0,       0, 0));

      @(negedge clk);
      foreach (vq[i]) apply(i, vq[i]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule : tb_stack_unit
`default_nettype wire
